// File: rtl/chan_pkg.sv
// Shared channelizer definitions: size/nfft widths, reconfiguration FSM
// state codes and the FFT-size to log2 lookup used across the datapath.
package chan_pkg;

   localparam int FFT_MIN        = 8;
   localparam int FFT_MAX        = 2048;
   localparam int FFT_SIZE_WIDTH = 12;
   localparam int NFFT_WIDTH     = 5;

   localparam logic [2:0] S_RUN    = 3'd0;
   localparam logic [2:0] S_DRAIN  = 3'd1;
   localparam logic [2:0] S_RESET  = 3'd2;
   localparam logic [2:0] S_POST   = 3'd3;
   localparam logic [2:0] S_CONFIG = 3'd4;

   typedef struct packed {
      logic                  valid;
      logic [NFFT_WIDTH-1:0] nfft;
   } size_dec_t;

   // Only exact powers of two inside the supported range decode as valid.
   function automatic size_dec_t size_to_nfft(input logic [FFT_SIZE_WIDTH-1:0] size);
      size_dec_t r;
      r.valid = 1'b1;
      r.nfft  = 5'd0;
      if ((size < FFT_SIZE_WIDTH'(FFT_MIN)) || (size > FFT_SIZE_WIDTH'(FFT_MAX))) begin
         r.valid = 1'b0;
      end else begin
         case (size)
            12'd8:    r.nfft = 5'd3;
            12'd16:   r.nfft = 5'd4;
            12'd32:   r.nfft = 5'd5;
            12'd64:   r.nfft = 5'd6;
            12'd128:  r.nfft = 5'd7;
            12'd256:  r.nfft = 5'd8;
            12'd512:  r.nfft = 5'd9;
            12'd1024: r.nfft = 5'd10;
            12'd2048: r.nfft = 5'd11;
            default:  r.valid = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/chan_size_decode.sv
// Combinational FFT size decoder: validity flag and nfft = log2(size).
module chan_size_decode
   import chan_pkg::*;
(
   input  logic [FFT_SIZE_WIDTH-1:0] size,
   output logic                      valid,
   output logic [NFFT_WIDTH-1:0]     nfft
);

   size_dec_t dec_s;

   // Decode the requested size through the shared lookup.
   always_comb begin
      dec_s = size_to_nfft(size);
      valid = dec_s.valid;
      nfft  = dec_s.nfft;
   end

endmodule

// File: rtl/chan_reconfig_ctrl.sv
// Run-time FFT-size reconfiguration sequencer: drain to a frame boundary,
// hold the datapath in reset, reissue the xfft config word, reopen input.
module chan_reconfig_ctrl
   import chan_pkg::*;
#(
   parameter int DEFAULT_FFT_SIZE  = 128,
   parameter int RESET_CYCLES      = 8,
   parameter int POST_RESET_CYCLES = 2,
   parameter int DRAIN_TIMEOUT     = 4096
) (
   input  logic                      clk,
   input  logic                      sync_reset,
   input  logic                      cfg_valid,
   input  logic [FFT_SIZE_WIDTH-1:0] cfg_fft_size,
   output logic                      cfg_busy,
   output logic                      cfg_error,
   output logic                      drain_timeout,
   output logic [FFT_SIZE_WIDTH-1:0] fft_size,
   input  logic                      in_tvalid,
   output logic                      in_tready,
   input  logic                      dp_tready,
   output logic                      dp_tvalid,
   input  logic                      out_tvalid,
   input  logic                      out_tready,
   input  logic                      out_tlast,
   output logic                      pipe_reset,
   output logic                      fft_aresetn,
   output logic                      fft_config_tvalid,
   output logic [15:0]               fft_config_tdata,
   input  logic                      fft_config_tready
);

   localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam int SEQ_W   = $clog2(RESET_CYCLES + POST_RESET_CYCLES + 1);
   localparam int CNT_W   = (DRAIN_W > SEQ_W) ? DRAIN_W : SEQ_W;

   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] POST_LAST  =
      CNT_W'((POST_RESET_CYCLES > 0) ? (POST_RESET_CYCLES - 1) : 0);

   localparam logic [FFT_SIZE_WIDTH-1:0] DEFAULT_SIZE = FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
   localparam logic [NFFT_WIDTH-1:0]     DEFAULT_NFFT = NFFT_WIDTH'($clog2(DEFAULT_FFT_SIZE));

   logic [2:0]                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [FFT_SIZE_WIDTH-1:0] fft_size_q, fft_size_d;
   logic [NFFT_WIDTH-1:0]     nfft_q, nfft_d;
   logic [FFT_SIZE_WIDTH-1:0] pend_size_q, pend_size_d;
   logic [NFFT_WIDTH-1:0]     pend_nfft_q, pend_nfft_d;
   logic                      pipe_reset_q, pipe_reset_d;
   logic                      fft_aresetn_q, fft_aresetn_d;
   logic                      cfg_tvalid_q, cfg_tvalid_d;
   logic                      cfg_busy_q, cfg_busy_d;
   logic                      cfg_error_q, cfg_error_d;
   logic                      drain_to_q, drain_to_d;
   logic                      gate_open_q, gate_open_d;

   logic                      req_valid_s;
   logic [NFFT_WIDTH-1:0]     req_nfft_s;
   logic                      frame_end_s;

   chan_size_decode u_req_decode (
      .size  (cfg_fft_size),
      .valid (req_valid_s),
      .nfft  (req_nfft_s)
   );

   assign frame_end_s = out_tvalid & out_tready & out_tlast;

   // Next-state logic for the reconfiguration sequence.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      fft_size_d    = fft_size_q;
      nfft_d        = nfft_q;
      pend_size_d   = pend_size_q;
      pend_nfft_d   = pend_nfft_q;
      pipe_reset_d  = pipe_reset_q;
      fft_aresetn_d = fft_aresetn_q;
      cfg_tvalid_d  = cfg_tvalid_q;
      cfg_busy_d    = cfg_busy_q;
      cfg_error_d   = 1'b0;
      drain_to_d    = drain_to_q;
      gate_open_d   = gate_open_q;

      if (cfg_valid && cfg_busy_q) begin
         cfg_error_d = 1'b1;
      end else begin
         cfg_error_d = 1'b0;
      end

      case (state_q)
         S_RUN: begin
            if (cfg_valid && !req_valid_s) begin
               cfg_error_d = 1'b1;
            end else if (cfg_valid && (cfg_fft_size != fft_size_q)) begin
               pend_size_d = cfg_fft_size;
               pend_nfft_d = req_nfft_s;
               drain_to_d  = 1'b0;
               cfg_busy_d  = 1'b1;
               gate_open_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_DRAIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            // A frame boundary on the same cycle as the timeout counts as a clean drain.
            if (frame_end_s || (cnt_q == DRAIN_LAST)) begin
               drain_to_d    = ~frame_end_s;
               pipe_reset_d  = 1'b1;
               fft_aresetn_d = 1'b0;
               cnt_d         = '0;
               state_d       = S_RESET;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESET: begin
            if (cnt_q == '0) begin
               fft_size_d = pend_size_q;
               nfft_d     = pend_nfft_q;
            end else begin
               fft_size_d = fft_size_q;
            end
            if (cnt_q == RESET_LAST) begin
               pipe_reset_d  = 1'b0;
               fft_aresetn_d = 1'b1;
               cnt_d         = '0;
               if (POST_RESET_CYCLES == 0) begin
                  cfg_tvalid_d = 1'b1;
                  state_d      = S_CONFIG;
               end else begin
                  state_d = S_POST;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_POST: begin
            if (cnt_q == POST_LAST) begin
               cfg_tvalid_d = 1'b1;
               cnt_d        = '0;
               state_d      = S_CONFIG;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CONFIG: begin
            if (fft_config_tready) begin
               cfg_tvalid_d = 1'b0;
               gate_open_d  = 1'b1;
               cfg_busy_d   = 1'b0;
               state_d      = S_RUN;
            end else begin
               cfg_tvalid_d = 1'b1;
            end
         end
         default: begin
            pipe_reset_d  = 1'b1;
            fft_aresetn_d = 1'b0;
            cfg_tvalid_d  = 1'b0;
            cfg_busy_d    = 1'b1;
            gate_open_d   = 1'b0;
            cnt_d         = '0;
            state_d       = S_RESET;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state_q       <= S_RESET;
         cnt_q         <= '0;
         fft_size_q    <= DEFAULT_SIZE;
         nfft_q        <= DEFAULT_NFFT;
         pend_size_q   <= DEFAULT_SIZE;
         pend_nfft_q   <= DEFAULT_NFFT;
         pipe_reset_q  <= 1'b1;
         fft_aresetn_q <= 1'b0;
         cfg_tvalid_q  <= 1'b0;
         cfg_busy_q    <= 1'b1;
         cfg_error_q   <= 1'b0;
         drain_to_q    <= 1'b0;
         gate_open_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fft_size_q    <= fft_size_d;
         nfft_q        <= nfft_d;
         pend_size_q   <= pend_size_d;
         pend_nfft_q   <= pend_nfft_d;
         pipe_reset_q  <= pipe_reset_d;
         fft_aresetn_q <= fft_aresetn_d;
         cfg_tvalid_q  <= cfg_tvalid_d;
         cfg_busy_q    <= cfg_busy_d;
         cfg_error_q   <= cfg_error_d;
         drain_to_q    <= drain_to_d;
         gate_open_q   <= gate_open_d;
      end
   end

   assign cfg_busy          = cfg_busy_q;
   assign cfg_error         = cfg_error_q;
   assign drain_timeout     = drain_to_q;
   assign fft_size          = fft_size_q;
   assign pipe_reset        = pipe_reset_q;
   assign fft_aresetn       = fft_aresetn_q;
   assign fft_config_tvalid = cfg_tvalid_q;
   assign fft_config_tdata  = {11'd0, nfft_q};
   assign in_tready         = dp_tready & gate_open_q;
   assign dp_tvalid         = in_tvalid & gate_open_q;

endmodule

// File: doc/chan_reconfig_ctrl.md
Name: chan_reconfig_ctrl

Overview:
Run-time reconfiguration sequencer for the M/2 channelizer datapath (input buffer, PFB, circular buffer, xfft, exponent shifter). It accepts an FFT-size change request and drains the datapath to an output frame boundary while stalling input. It then holds the datapath in reset, re-issues the xfft config word, and re-opens the input. It replaces free-running size-change detection with an explicit, observable handshake.

Parameters:
DEFAULT_FFT_SIZE, 128, size loaded at sync_reset; must be a power of 2 in 8..2048
RESET_CYCLES, 8, cycles pipe_reset/fft_aresetn held active; minimum 2
POST_RESET_CYCLES, 2, idle cycles after fft_aresetn release before the config word is presented
DRAIN_TIMEOUT, 4096, cycles to wait for a frame boundary before forcing reset; counter width clog2(DRAIN_TIMEOUT+1)

Ports:
clk  in  1  clock
sync_reset  in  1  reset, asynchronous, active-high
cfg_valid  in  1  one-cycle request strobe
cfg_fft_size  in  12  requested FFT size, sampled when cfg_valid=1
cfg_busy  out  1  sequence in progress; requests are ignored while high
cfg_error  out  1  one-cycle pulse: invalid size, or request while busy
drain_timeout  out  1  sticky flag: last drain ended by timeout; cleared by next accepted request
fft_size  out  12  registered active size to all datapath blocks
in_tvalid  in  1  upstream sample valid
in_tready  out  1  to upstream: datapath ready AND gate_open
dp_tready  in  1  datapath s_axis_tready
dp_tvalid  out  1  to datapath: in_tvalid AND gate_open
out_tvalid  in  1  monitor of datapath m_axis_tvalid
out_tready  in  1  monitor of datapath m_axis_tready
out_tlast  in  1  monitor of datapath m_axis_tlast
pipe_reset  out  1  active-high synchronous reset to datapath blocks
fft_aresetn  out  1  xfft aresetn, active-low
fft_config_tvalid  out  1  xfft config channel valid
fft_config_tdata  out  16  {11'b0, nfft}, nfft = log2(fft_size)
fft_config_tready  in  1  xfft config channel ready

Behaviour:
- All outputs registered except the gated tready/tvalid combinational pair.
- Reset values:
  - state=S_RESET, fft_size=DEFAULT_FFT_SIZE, nfft=log2(DEFAULT_FFT_SIZE)
  - pipe_reset=1, fft_aresetn=0, fft_config_tvalid=0
  - cfg_busy=1, cfg_error=0, drain_timeout=0, gate_open=0, counters=0
- Valid sizes: 8,16,32,64,128,256,512,1024,2048 only. nfft is 3..11 from a priority lookup and is registered with fft_size.
- S_RUN:
  - gate_open=1, cfg_busy=0.
  - cfg_valid with invalid size: cfg_error=1 next cycle, stay.
  - cfg_valid with valid size equal to fft_size: no-op, no error.
  - cfg_valid with valid different size: latch pending size, clear drain_timeout, go S_DRAIN; cfg_busy=1 next cycle.
- S_DRAIN:
  - gate_open=0 from the first cycle in this state, so in_tready=0 and dp_tvalid=0.
  - Exit to S_RESET on out_tvalid&out_tready&out_tlast. This cycle's transfer completes normally.
  - Also exit to S_RESET when the counter reaches DRAIN_TIMEOUT-1; set drain_timeout=1 in that case.
  - If tlast and timeout coincide, tlast wins: drain_timeout stays 0.
- S_RESET:
  - pipe_reset=1, fft_aresetn=0 for exactly RESET_CYCLES cycles.
  - fft_size and nfft are loaded from pending on the first cycle.
  - Then go S_POST with pipe_reset=0, fft_aresetn=1.
- S_POST: wait POST_RESET_CYCLES cycles, then assert fft_config_tvalid and go S_CONFIG.
- S_CONFIG:
  - Hold fft_config_tvalid and stable tdata until fft_config_tready=1.
  - On the handshake cycle: tvalid drops next cycle, go S_RUN, gate_open=1, cfg_busy=0.
  - No timeout; xfft must accept.
- cfg_valid while cfg_busy=1: request ignored, cfg_error pulse.
- sync_reset at any time returns to reset values and replays S_RESET→S_POST→S_CONFIG with DEFAULT_FFT_SIZE.
- Latency: accepted request to in_tready re-open = drain time + RESET_CYCLES + POST_RESET_CYCLES + config handshake cycles + 1.

Decomposition:
- Shared package chan_pkg:
  - FFT_MIN=8, FFT_MAX=2048, FFT_SIZE_WIDTH=12, NFFT_WIDTH=5
  - state encoding constants S_RUN/S_DRAIN/S_RESET/S_POST/S_CONFIG
  - size-to-nfft function with its validity flag
- One sub-module is natural: chan_size_decode (combinational size→{valid,nfft}), reused by the datapath blocks.
- The rest (FSM, counters, gating) stays flat.

Test Plan:
- Power-up: release sync_reset, fft_config_tready=1 → pipe_reset high 8 cycles; config tdata=16'h0007 after 2 idle cycles; fft_size=128; in_tready follows dp_tready.
- Request 1024 mid-frame: in_tready=0 next cycle; after out_tlast handshake, pipe_reset 8 cycles; config tdata=16'h000A; fft_size=1024; drain_timeout=0.
- Request 256 with no out_tlast: drain_timeout=1 exactly DRAIN_TIMEOUT cycles after entering S_DRAIN; config tdata=16'h0008.
- Invalid requests 100, 4096, 0 → single-cycle cfg_error each, fft_size unchanged, cfg_busy stays 0.
- cfg_valid during S_CONFIG, with fft_config_tready held low 20 cycles → cfg_error pulse; tvalid/tdata held stable 20 cycles; completes with the original size.
- sync_reset asserted during S_DRAIN → immediate reset values; sequence replays with 128, config tdata=16'h0007.
